// File: rtl/ro_pair_if.sv
// ro_pair_if: start/done handshake and result bus between a measurement master and ro_pair_counter
interface ro_pair_if #(parameter int CNT_W = 16);
  logic start;
  logic ready;
  logic done;
  logic resp;
  logic tie;
  logic ovf_a;
  logic ovf_b;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  modport master (output start, input ready, done, resp, tie, ovf_a, ovf_b, cnt_a, cnt_b);
  modport slave (input start, output ready, done, resp, tie, ovf_a, ovf_b, cnt_a, cnt_b);
endinterface

// File: rtl/ro_pair_counter.sv
// ro_pair_counter: runs an RO pair for a fixed clk window, counts both ROs' rising edges and emits one PUF bit
module ro_pair_counter #(
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1024,
  parameter int SETTLE = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  ro_pair_if.slave bus,
  output logic     ro_en,
  output logic     ro_rst,
  input  logic     ro_a,
  input  logic     ro_b
);
  localparam int DRAIN_N = 3;
  localparam int LONG = WINDOW > SETTLE ? WINDOW : SETTLE;
  localparam int WW = $clog2((LONG > DRAIN_N ? LONG : DRAIN_N) + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  typedef enum logic [2:0] {IDLE, RESET, RUN, DRAIN, DONE} state_t;
  state_t state, state_d;
  logic [WW-1:0] wcnt, wcnt_d;
  logic [1:0] sync_a, sync_b;
  logic prev_a, prev_b, edge_a, edge_b, counting, last, accept;
  logic [CNT_W-1:0] next_a, next_b;
  assign last = wcnt == WW'(1);
  assign accept = state == IDLE && bus.start;
  assign counting = state == RUN || state == DRAIN;
  // DRAIN keeps counting so edges still in the sync/edge pipe at end of RUN are not lost
  assign edge_a = counting && sync_a[1] && !prev_a;
  assign edge_b = counting && sync_b[1] && !prev_b;
  assign next_a = edge_a && bus.cnt_a != CMAX ? bus.cnt_a + CNT_W'(1) : bus.cnt_a;
  assign next_b = edge_b && bus.cnt_b != CMAX ? bus.cnt_b + CNT_W'(1) : bus.cnt_b;
  always_comb begin
    state_d = state;
    wcnt_d = wcnt - WW'(1);
    ro_en = 1'b0;
    ro_rst = 1'b1;
    bus.ready = 1'b0;
    bus.done = 1'b0;
    case (state)
      IDLE: begin
        bus.ready = 1'b1;
        wcnt_d = WW'(SETTLE);
        state_d = bus.start ? RESET : IDLE;
      end
      RESET: begin
        ro_en = 1'b1;
        if (last) begin
          state_d = RUN;
          wcnt_d = WW'(WINDOW);
        end
      end
      RUN: begin
        ro_en = 1'b1;
        ro_rst = 1'b0;
        if (last) begin
          state_d = DRAIN;
          wcnt_d = WW'(DRAIN_N);
        end
      end
      DRAIN: state_d = last ? DONE : DRAIN;
      DONE: begin
        bus.done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wcnt <= '0;
      sync_a <= '0;
      sync_b <= '0;
      prev_a <= 1'b0;
      prev_b <= 1'b0;
      bus.cnt_a <= '0;
      bus.cnt_b <= '0;
      bus.ovf_a <= 1'b0;
      bus.ovf_b <= 1'b0;
      bus.resp <= 1'b0;
      bus.tie <= 1'b0;
    end else begin
      state <= state_d;
      wcnt <= wcnt_d;
      sync_a <= {sync_a[0], ro_a};
      sync_b <= {sync_b[0], ro_b};
      prev_a <= sync_a[1];
      prev_b <= sync_b[1];
      if (accept) begin
        bus.cnt_a <= '0;
        bus.cnt_b <= '0;
        bus.ovf_a <= 1'b0;
        bus.ovf_b <= 1'b0;
        bus.resp <= 1'b0;
        bus.tie <= 1'b0;
      end else begin
        bus.cnt_a <= next_a;
        bus.cnt_b <= next_b;
        bus.ovf_a <= bus.ovf_a || (edge_a && next_a == CMAX);
        bus.ovf_b <= bus.ovf_b || (edge_b && next_b == CMAX);
        // compare the post-increment values so an edge in the last DRAIN cycle is included
        if (state == DRAIN && last) begin
          bus.resp <= next_a > next_b;
          bus.tie <= next_a == next_b;
        end
      end
    end
  end
endmodule
